// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the configurable UART receiver
//
// Contents: rx_state_t (receiver FSM states), par_mode_t (parity encodings),
// rx_frame_t (one received frame as stored in the output FIFO), SYNC_STAGES,
// MAX_DATA_W and the 3-input majority helper maj3().
package uart_pkg;

    localparam int SYNC_STAGES = 2;

    // The frame struct is sized for the widest supported word; narrower
    // configurations zero-extend into it and only use the low bits.
    localparam int MAX_DATA_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // 2'b11 is deliberately left unnamed: it behaves like PAR_NONE.
    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } par_mode_t;

    typedef struct packed {
        logic                  brk;
        logic                  ferr;
        logic                  perr;
        logic [MAX_DATA_W-1:0] data;
    } rx_frame_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - received-frame stream between the UART receiver and its consumer
//
// Signals: m_data (frame data), m_perr/m_ferr/m_brk (frame status),
// m_valid (frame available), m_ready (consumer accepts; pop on valid&&ready).
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_cfg_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] m_data;
    logic              m_perr;
    logic              m_ferr;
    logic              m_brk;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output m_data,
        output m_perr,
        output m_ferr,
        output m_brk,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_perr,
        input  m_ferr,
        input  m_brk,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous FIFO of received frames
//
// Ports: clk, rst (async, active-high); wr_en/wr_data/full write side;
// rd_en/rd_data/empty read side (rd_data is the head entry, valid when !empty);
// level = number of entries held, 0..DEPTH.
// A write while full is accepted only when a read happens in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  rx_frame_t                wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output rx_frame_t                rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    rx_frame_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (level_q == '0);
    assign full    = (level_q == FULL_LVL);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers are power-of-two wide, so natural overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_wr && !do_rd) begin
                level_q <= level_q + 1'b1;
            end else if (do_rd && !do_wr) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - UART receiver with runtime baud/parity/stop config and output FIFO
//
// Ports: clk, rst (async, active-high); rx serial input (async, idle high);
// baud_div (tick period = baud_div+1 clocks); par_mode (00/11 none, 01 even,
// 10 odd); stop2 (check two stop bits); m_if (master) frame stream with
// data and perr/ferr/brk status; fifo_level (entries held); overrun (sticky,
// frame dropped on full FIFO) with clr_ovr clear pulse; busy (FSM not IDLE).
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic [1:0]                  par_mode,
    input  logic                        stop2,
    uart_rx_cfg_if.master               m_if,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overrun,
    input  logic                        clr_ovr,
    output logic                        busy
);

    localparam int S_W = $clog2(OVERSAMPLE);
    localparam int B_W = $clog2(DATA_W);

    // Three samples straddle mid-bit; the vote is taken on the last of them.
    localparam logic [S_W-1:0] S_SAMP0 = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_SAMP1 = S_W'(OVERSAMPLE / 2);
    localparam logic [S_W-1:0] S_DEC   = S_W'(OVERSAMPLE / 2 + 1);
    localparam logic [S_W-1:0] S_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [B_W-1:0] B_LAST  = B_W'(DATA_W - 1);

    // ------------------------------------------------------------------
    // Input synchroniser (resets to idle-high so no false start on exit)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    rx_state_t        state_q;
    logic             armed_q;
    logic [S_W-1:0]   s_q;
    logic [B_W-1:0]   bit_idx_q;
    logic [DATA_W-1:0] shift_q;
    logic [1:0]       samp_q;
    logic [1:0]       par_q;
    logic             stop2_q;
    logic             second_q;
    logic             perr_q;
    logic             ferr_q;
    logic             par_bit_q;
    logic             wr_q;
    rx_frame_t        wr_frame_q;

    logic start_go;
    logic tick;
    logic maj;
    logic dec;
    logic last_tick;
    logic par_en;
    logic par_odd;
    logic ferr_fin;

    assign start_go  = (state_q == ST_IDLE) && armed_q && !rxs;
    assign maj       = maj3(samp_q[0], samp_q[1], rxs);
    assign dec       = tick && (s_q == S_DEC);
    assign last_tick = tick && (s_q == S_LAST);
    assign par_en    = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign par_odd   = (par_q == PAR_ODD);
    assign ferr_fin  = ferr_q | ~maj;

    // ------------------------------------------------------------------
    // Tick generator; restarted on the start edge so sampling phase is
    // referenced to the falling edge rather than a free-running count.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] tick_cnt_q;
    logic [DIV_W-1:0] tick_cnt_d;

    assign tick = (tick_cnt_q >= baud_div);

    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (start_go || tick) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b0;
            s_q        <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            samp_q     <= '0;
            par_q      <= PAR_NONE;
            stop2_q    <= 1'b0;
            second_q   <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            par_bit_q  <= 1'b0;
            wr_q       <= 1'b0;
            wr_frame_q <= '0;
        end else begin
            wr_q <= 1'b0;

            // Bit-time counter and sample capture are common to all
            // in-frame states.
            if (state_q != ST_IDLE && tick) begin
                s_q <= (s_q == S_LAST) ? '0 : s_q + 1'b1;
                if (s_q == S_SAMP0) begin
                    samp_q[0] <= rxs;
                end
                if (s_q == S_SAMP1) begin
                    samp_q[1] <= rxs;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (rxs) begin
                        armed_q <= 1'b1;
                    end
                    if (start_go) begin
                        // Config is frozen for the whole frame.
                        state_q   <= ST_START;
                        s_q       <= '0;
                        bit_idx_q <= '0;
                        par_q     <= par_mode;
                        stop2_q   <= stop2;
                        second_q  <= 1'b0;
                        perr_q    <= 1'b0;
                        ferr_q    <= 1'b0;
                        par_bit_q <= 1'b0;
                    end
                end

                ST_START: begin
                    if (dec && maj) begin
                        state_q <= ST_IDLE;
                        armed_q <= 1'b1;
                    end else if (last_tick) begin
                        state_q <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (dec) begin
                        shift_q <= {maj, shift_q[DATA_W-1:1]};
                    end
                    if (last_tick) begin
                        if (bit_idx_q == B_LAST) begin
                            state_q <= par_en ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (dec) begin
                        par_bit_q <= maj;
                        perr_q    <= ((^shift_q) ^ maj) != par_odd;
                    end
                    if (last_tick) begin
                        state_q <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (dec) begin
                        if (stop2_q && !second_q) begin
                            // First of two stop bits; the second is voted one
                            // bit-time later as s_q keeps wrapping.
                            second_q <= 1'b1;
                            ferr_q   <= ferr_fin;
                        end else begin
                            wr_q            <= 1'b1;
                            wr_frame_q.data <= MAX_DATA_W'(shift_q);
                            wr_frame_q.perr <= perr_q;
                            wr_frame_q.ferr <= ferr_fin;
                            wr_frame_q.brk  <= ferr_fin && (shift_q == '0)
                                               && (!par_en || !par_bit_q);
                            state_q         <= ST_IDLE;
                            // A low stop bit leaves the line low: wait for
                            // it to return high before accepting a start.
                            armed_q         <= maj;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO, overrun flag and stream outputs
    // ------------------------------------------------------------------
    logic      fifo_full;
    logic      fifo_empty;
    logic      pop;
    logic      overrun_q;
    rx_frame_t head;
    logic      unused_head_data;

    assign pop = m_if.m_ready && !fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_q),
        .wr_data (wr_frame_q),
        .full    (fifo_full),
        .rd_en   (m_if.m_ready),
        .rd_data (head),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (wr_q && fifo_full && !pop) begin
            overrun_q <= 1'b1;
        end else if (clr_ovr) begin
            overrun_q <= 1'b0;
        end
    end

    // Head fields are forced to 0 while empty so stale storage never shows.
    assign m_if.m_valid = !fifo_empty;
    assign m_if.m_data  = fifo_empty ? '0 : head.data[DATA_W-1:0];
    assign m_if.m_perr  = !fifo_empty && head.perr;
    assign m_if.m_ferr  = !fifo_empty && head.ferr;
    assign m_if.m_brk   = !fifo_empty && head.brk;

    assign unused_head_data = ^head.data;

    assign overrun = overrun_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int OS = 16;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] baud_div = 16'd53;
    logic [1:0]  par_mode = 2'b00;
    logic        stop2 = 1'b0;
    logic        clr_ovr = 1'b0;
    logic [2:0]  fifo_level;
    logic        overrun;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int valid_cycles = 0;
    ent_t got_q[$];

    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_W(8)) m_if ();

    uart_rx_cfg #(
        .DATA_W(8), .OVERSAMPLE(OS), .DIV_W(16), .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .baud_div   (baud_div),
        .par_mode   (par_mode),
        .stop2      (stop2),
        .m_if       (m_if),
        .fifo_level (fifo_level),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr),
        .busy       (busy)
    );

    // Consumer-side monitor: record every accepted frame, count valid cycles.
    always @(negedge clk) begin
        if (m_if.m_valid === 1'b1) begin
            valid_cycles++;
            if (m_if.m_ready === 1'b1)
                got_q.push_back({m_if.m_brk, m_if.m_ferr, m_if.m_perr, m_if.m_data});
        end
    end

    // Reference model: expected FIFO entry from what was put on the wire.
    function automatic ent_t model(input logic [7:0] d, input logic [1:0] pm,
                                   input logic pbit, input logic s2, input logic [1:0] stops);
        ent_t e;
        logic pen;
        int   ones;
        pen    = (pm == 2'b01) || (pm == 2'b10);
        ones   = $countones(d) + ((pen && pbit) ? 1 : 0);
        e.d    = d;
        e.perr = pen && ((ones % 2) != ((pm == 2'b10) ? 1 : 0));
        e.ferr = !stops[0] || (s2 && !stops[1]);
        e.brk  = e.ferr && (d == 8'h00) && (!pen || !pbit);
        return e;
    endfunction

    function automatic logic good_pbit(input logic [7:0] d, input logic [1:0] pm);
        return (pm == 2'b10) ? ~(^d) : (^d);
    endfunction

    function automatic ent_t pop_got();
        if (got_q.size() == 0) return 'x;
        return got_q.pop_front();
    endfunction

    function automatic int bit_clks();
        return OS * (int'(baud_div) + 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic pbit,
                        input logic s2, input logic [1:0] stops);
        logic [11:0] bits;
        int nb;
        par_mode = pm;
        stop2    = s2;
        bits     = '1;
        bits[0]  = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        nb = 9;
        if (pm == 2'b01 || pm == 2'b10) begin bits[nb] = pbit; nb++; end
        bits[nb] = stops[0]; nb++;
        if (s2) begin bits[nb] = stops[1]; nb++; end
        for (int i = 0; i < nb; i++) begin
            rx = bits[i];
            repeat (bit_clks()) step();
        end
        rx = 1'b1;
        repeat (bit_clks()) step();
    endtask

    task automatic wait_n(input int n);
        for (int k = 0; k < 20000 && got_q.size() < n; k++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_cmp++;
        if ({m_if.m_valid, m_if.m_perr, m_if.m_ferr, m_if.m_brk} !== 4'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000", {m_if.m_valid, m_if.m_perr, m_if.m_ferr, m_if.m_brk});
        end
        n_cmp++;
        if (m_if.m_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", m_if.m_data); end
        n_cmp++;
        if ({fifo_level, overrun, busy} !== 5'b0) begin
            n_bad++; $display("FAIL reset_status: got %b want 00000", {fifo_level, overrun, busy});
        end
        rst = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_8n1();
        ent_t g, e;
        baud_div = 16'd53;
        got_q.delete();
        valid_cycles = 0;
        send(8'hA5, 2'b00, 1'b0, 1'b0, 2'b11);
        wait_n(1);
        repeat (20) step();
        n_cmp++;
        if (got_q.size() != 1) begin n_bad++; $display("FAIL 8n1_count: got %0d want 1", got_q.size()); end
        g = pop_got();
        n_cmp++;
        if (g !== 11'h0A5) begin n_bad++; $display("FAIL 8n1_entry: got %h want 0a5", g); end
        n_cmp++;
        if (valid_cycles != 1) begin n_bad++; $display("FAIL 8n1_valid_cycles: got %0d want 1", valid_cycles); end
        // Random 8N1 frames at faster divisors.
        baud_div = 16'($urandom_range(1, 4));
        for (int i = 0; i < 3; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            e = model(d, 2'b00, 1'b0, 1'b0, 2'b11);
            send(d, 2'b00, 1'b0, 1'b0, 2'b11);
            wait_n(1);
            g = pop_got();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL 8n1_rand%0d: got %h want %h", i, g, e); end
        end
    endtask

    task automatic test_parity();
        ent_t g, e;
        baud_div = 16'($urandom_range(1, 4));
        got_q.delete();
        send(8'h03, 2'b01, 1'b1, 1'b0, 2'b11);
        wait_n(1);
        g = pop_got();
        n_cmp++;
        if (g !== {1'b0, 1'b0, 1'b1, 8'h03}) begin n_bad++; $display("FAIL parity_bad: got %h want 103", g); end
        send(8'h03, 2'b01, 1'b0, 1'b0, 2'b11);
        wait_n(1);
        g = pop_got();
        n_cmp++;
        if (g !== 11'h003) begin n_bad++; $display("FAIL parity_good: got %h want 003", g); end
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            logic [1:0] pm, st;
            logic pb, s2;
            d  = 8'($urandom);
            pm = 2'($urandom_range(0, 3));
            pb = ($urandom_range(0, 2) == 0) ? ~good_pbit(d, pm) : good_pbit(d, pm);
            s2 = 1'($urandom);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            e  = model(d, pm, pb, s2, st);
            send(d, pm, pb, s2, st);
            wait_n(1);
            g = pop_got();
            n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL parity_rand%0d pm=%b s2=%b: got %h want %h", i, pm, s2, g, e);
            end
        end
    endtask

    task automatic test_glitch();
        ent_t g;
        baud_div = 16'($urandom_range(2, 4));
        par_mode = 2'b00;
        stop2    = 1'b0;
        got_q.delete();
        rx = 1'b0;
        repeat (4 * (int'(baud_div) + 1)) step();
        rx = 1'b1;
        repeat (3 * bit_clks()) step();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy: got %b want 0", busy); end
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL glitch_entries: got %0d want 0", got_q.size()); end
        send(8'h5A, 2'b00, 1'b0, 1'b0, 2'b11);
        wait_n(1);
        g = pop_got();
        n_cmp++;
        if (g !== 11'h05A) begin n_bad++; $display("FAIL glitch_next: got %h want 05a", g); end
    endtask

    task automatic test_break();
        ent_t g;
        baud_div = 16'($urandom_range(1, 4));
        par_mode = 2'b00;
        stop2    = 1'b0;
        got_q.delete();
        rx = 1'b0;
        repeat (12 * bit_clks()) step();
        n_cmp++;
        if (got_q.size() != 1) begin n_bad++; $display("FAIL break_count: got %0d want 1", got_q.size()); end
        g = pop_got();
        n_cmp++;
        if (g !== {1'b1, 1'b1, 1'b0, 8'h00}) begin n_bad++; $display("FAIL break_entry: got %h want 600", g); end
        rx = 1'b1;
        repeat (2 * bit_clks()) step();
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL break_extra: got %0d want 0", got_q.size()); end
        send(8'h3C, 2'b00, 1'b0, 1'b0, 2'b11);
        wait_n(1);
        g = pop_got();
        n_cmp++;
        if (g !== 11'h03C) begin n_bad++; $display("FAIL break_next: got %h want 03c", g); end
    endtask

    task automatic test_overrun();
        ent_t g;
        baud_div = 16'd2;
        got_q.delete();
        m_if.m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(8'(i), 2'b00, 1'b0, 1'b0, 2'b11);
        n_cmp++;
        if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL ovr_level: got %0d want 4", fifo_level); end
        n_cmp++;
        if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL ovr_no_pop: got %0d want 0", got_q.size()); end
        m_if.m_ready = 1'b1;
        repeat (10) step();
        for (int i = 1; i <= 4; i++) begin
            g = pop_got();
            n_cmp++;
            if (g !== {3'b000, 8'(i)}) begin n_bad++; $display("FAIL ovr_drain%0d: got %h want %h", i, g, 8'(i)); end
        end
        n_cmp++;
        if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL ovr_level_after: got %0d want 0", fifo_level); end
        n_cmp++;
        if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_stop2();
        ent_t g, e;
        logic [7:0] d;
        baud_div = 16'($urandom_range(1, 4));
        got_q.delete();
        send(8'h96, 2'b00, 1'b0, 1'b1, 2'b01);
        wait_n(1);
        g = pop_got();
        n_cmp++;
        if (g !== {1'b0, 1'b1, 1'b0, 8'h96}) begin n_bad++; $display("FAIL stop2_second0: got %h want 296", g); end
        d = 8'($urandom);
        e = model(d, 2'b10, good_pbit(d, 2'b10), 1'b1, 2'b11);
        send(d, 2'b10, good_pbit(d, 2'b10), 1'b1, 2'b11);
        wait_n(1);
        g = pop_got();
        n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL stop2_good: got %h want %h", g, e); end
        d = 8'($urandom);
        e = model(d, 2'b00, 1'b0, 1'b1, 2'b10);
        send(d, 2'b00, 1'b0, 1'b1, 2'b10);
        wait_n(1);
        g = pop_got();
        n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL stop2_first0: got %h want %h", g, e); end
    endtask

    task automatic test_reset_mid();
        ent_t g, e;
        logic [7:0] d;
        baud_div = 16'($urandom_range(1, 4));
        par_mode = 2'b00;
        stop2    = 1'b0;
        got_q.delete();
        rx = 1'b0;
        repeat (bit_clks()) step();
        rx = 1'b1;
        repeat (2 * bit_clks()) step();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        repeat (3) step();
        n_cmp++;
        if ({m_if.m_valid, m_if.m_perr, m_if.m_ferr, m_if.m_brk, m_if.m_data, fifo_level, overrun, busy} !== 17'b0) begin
            n_bad++; $display("FAIL rstmid_outputs: got %h want 0",
                {m_if.m_valid, m_if.m_perr, m_if.m_ferr, m_if.m_brk, m_if.m_data, fifo_level, overrun, busy});
        end
        rst = 1'b0;
        repeat (12 * bit_clks()) step();
        n_cmp++;
        if (got_q.size() != 0) begin n_bad++; $display("FAIL rstmid_no_entry: got %0d want 0", got_q.size()); end
        d = 8'($urandom);
        e = model(d, 2'b00, 1'b0, 1'b0, 2'b11);
        send(d, 2'b00, 1'b0, 1'b0, 2'b11);
        wait_n(1);
        g = pop_got();
        n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL rstmid_next: got %h want %h", g, e); end
    endtask

    initial begin
        m_if.m_ready = 1'b1;
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_break();
        test_overrun();
        test_stop2();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
